// File: rtl/out_port_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | out_port_uart_tx : 8N1 serial transmitter fed by the output port latch.    |
// |                    It has a one-byte holding register and a sticky overrun |
// |                    flag.                                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       ovr_clr,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       hold_full,
  output logic       tx_overrun
);

  localparam int            CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ovr_q, ovr_d;
  logic             tx_q, tx_d;
  logic             xfer;
  logic             bit_end;

  assign bit_end = (cnt_q == C_BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      tx_q        <= tx_d;
    end
  end

  // The line level is computed one cycle ahead, so tx_serial is a plain flop output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    tx_d        = tx_q;
    xfer        = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          xfer    = 1'b1;
          shift_d = hold_q;
          cnt_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (hold_full_q) begin
            xfer    = 1'b1;
            shift_d = hold_q;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // A byte leaving for the shifter frees the holding register in the same cycle.
    if (xfer) begin
      hold_full_d = 1'b0;
    end
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (tx_load) begin
      if (!hold_full_q || xfer) begin
        hold_d      = tx_data;
        hold_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign tx_serial  = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign hold_full  = hold_full_q;
  assign tx_overrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_out_port_uart_tx.sv
`default_nettype none
// Testbench for out_port_uart_tx: the scoreboard holds the bytes expected on the
// serial line, and the scenario tasks check timing and flags directly.
module tb_out_port_uart_tx;

  localparam int CPB  = 4;
  localparam int HMAX = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       tx_serial, tx_busy, hold_full, tx_overrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] sb[$];

  logic tx_hist   [0:511];
  logic hold_hist [0:511];
  logic ovr_hist  [0:511];
  logic e0_hold, e0_busy, e0_tx;

  logic [7:0] seq_dat [4];
  int         seq_at  [4];
  bit         seq_push[4];

  out_port_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .ovr_clr    (ovr_clr),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .hold_full  (hold_full),
    .tx_overrun (tx_overrun)
  );

  always #5 clk = ~clk;

  // Frame receiver: samples each bit period on falling edges and checks each
  // decoded byte against the front of the scoreboard.
  initial begin : mon
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         abort_f, glitch;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_serial === 1'b0) begin
        bits    = '0;
        abort_f = 1'b0;
        glitch  = 1'b0;
        for (int c = 1; c < 10 * CPB; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            abort_f = 1'b1;
            break;
          end
          if (c % CPB == 0) bits[c / CPB] = tx_serial;
          else if (tx_serial !== bits[c / CPB]) glitch = 1'b1;
        end
        if (!abort_f) begin
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL frame: got unexpected frame data=%h, expected no frame", bits[8:1]);
          end else begin
            exp_b = sb.pop_front();
            if (bits[8:1] !== exp_b || bits[9] !== 1'b1 || glitch) begin
              tests_failed++;
              $display("FAIL frame: got data=%h stop=%b glitch=%0d, expected data=%h stop=1 glitch=0",
                       bits[8:1], bits[9], glitch, exp_b);
            end
          end
        end
      end
    end
  end

  // Loads `first`, then drives the queued extra loads at frame-relative cycles.
  // t=0 is the first start-bit cycle. The run stops when tx_busy falls.
  task automatic run_seq(input logic [7:0] first, input int n, input int clr_at,
                         output int busy_len);
    int t;
    @(negedge clk);
    tx_data = first;
    tx_load = 1'b1;
    sb.push_back(first);
    @(negedge clk);
    tx_load = 1'b0;
    e0_hold = hold_full;
    e0_busy = tx_busy;
    e0_tx   = tx_serial;
    @(negedge clk);
    busy_len = 0;
    t = 0;
    while (tx_busy === 1'b1 && t < HMAX) begin
      tx_hist[t]   = tx_serial;
      hold_hist[t] = hold_full;
      ovr_hist[t]  = tx_overrun;
      busy_len++;
      tx_load = 1'b0;
      ovr_clr = (t == clr_at);
      for (int i = 0; i < n; i++) begin
        if (seq_at[i] == t) begin
          tx_data = seq_dat[i];
          tx_load = 1'b1;
          if (seq_push[i]) sb.push_back(seq_dat[i]);
        end
      end
      @(negedge clk);
      t++;
    end
    tx_load = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run += 4;
    if (tx_serial !== 1'b1) begin tests_failed++; $display("FAIL reset_serial: got %b, expected 1", tx_serial); end
    if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", tx_busy); end
    if (hold_full !== 1'b0) begin tests_failed++; $display("FAIL reset_hold: got %b, expected 0", hold_full); end
    if (tx_overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr: got %b, expected 0", tx_overrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int         blen;
    logic [9:0] frame;
    logic [7:0] b;
    b = 8'hA5;
    frame = {1'b1, b, 1'b0};
    run_seq(b, 0, -1, blen);
    tests_run += 4;
    if (e0_hold !== 1'b1) begin tests_failed++; $display("FAIL single_e0_hold: got %b, expected 1", e0_hold); end
    if (e0_busy !== 1'b0 || e0_tx !== 1'b1) begin
      tests_failed++; $display("FAIL single_e0_line: got busy=%b tx=%b, expected busy=0 tx=1", e0_busy, e0_tx);
    end
    if (blen != 10 * CPB) begin tests_failed++; $display("FAIL single_busy_len: got %0d, expected %0d", blen, 10 * CPB); end
    if (hold_hist[0] !== 1'b0) begin tests_failed++; $display("FAIL single_e1_hold: got %b, expected 0", hold_hist[0]); end
    for (int t = 0; t < 10 * CPB; t++) begin
      tests_run++;
      if (tx_hist[t] !== frame[t / CPB]) begin
        tests_failed++;
        $display("FAIL single_level[%0d]: got %b, expected %b", t, tx_hist[t], frame[t / CPB]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int blen;
    seq_dat[0] = 8'h81; seq_at[0] = 8; seq_push[0] = 1'b1;
    run_seq(8'h3C, 1, -1, blen);
    tests_run += 5;
    if (hold_hist[9] !== 1'b1 || hold_hist[39] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_hold_held: got t9=%b t39=%b, expected 1 1", hold_hist[9], hold_hist[39]);
    end
    if (hold_hist[40] !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold_drop: got %b, expected 0", hold_hist[40]); end
    if (tx_hist[39] !== 1'b1 || tx_hist[40] !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_gap: got t39=%b t40=%b, expected 1 0", tx_hist[39], tx_hist[40]);
    end
    if (blen != 20 * CPB) begin tests_failed++; $display("FAIL b2b_busy_len: got %0d, expected %0d", blen, 20 * CPB); end
    if (tx_overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovr: got %b, expected 0", tx_overrun); end
  endtask

  task automatic test_overrun();
    int blen;
    seq_dat[0] = 8'h22; seq_at[0] = 8;  seq_push[0] = 1'b1;
    seq_dat[1] = 8'h33; seq_at[1] = 12; seq_push[1] = 1'b0;
    run_seq(8'h11, 2, -1, blen);
    tests_run += 3;
    if (ovr_hist[12] !== 1'b0 || ovr_hist[13] !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_set: got t12=%b t13=%b, expected 0 1", ovr_hist[12], ovr_hist[13]);
    end
    if (hold_hist[13] !== 1'b1) begin tests_failed++; $display("FAIL ovr_hold: got %b, expected 1", hold_hist[13]); end
    if (blen != 20 * CPB) begin tests_failed++; $display("FAIL ovr_busy_len: got %0d, expected %0d", blen, 20 * CPB); end
  endtask

  task automatic test_ovr_clr();
    int blen;
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    tests_run++;
    if (tx_overrun !== 1'b0) begin tests_failed++; $display("FAIL clr_alone: got %b, expected 0", tx_overrun); end
    seq_dat[0] = 8'h55; seq_at[0] = 8;  seq_push[0] = 1'b1;
    seq_dat[1] = 8'h66; seq_at[1] = 12; seq_push[1] = 1'b0;
    run_seq(8'h44, 2, 12, blen);
    tests_run += 2;
    if (ovr_hist[12] !== 1'b0 || ovr_hist[13] !== 1'b1) begin
      tests_failed++; $display("FAIL clr_vs_set: got t12=%b t13=%b, expected 0 1", ovr_hist[12], ovr_hist[13]);
    end
    if (blen != 20 * CPB) begin tests_failed++; $display("FAIL clr_busy_len: got %0d, expected %0d", blen, 20 * CPB); end
  endtask

  task automatic test_stop_start_load();
    int blen;
    seq_dat[0] = 8'h5A; seq_at[0] = 8;  seq_push[0] = 1'b1;
    seq_dat[1] = 8'hE7; seq_at[1] = 39; seq_push[1] = 1'b1;
    run_seq(8'hC3, 2, 0, blen);
    tests_run += 5;
    if (ovr_hist[1] !== 1'b0) begin tests_failed++; $display("FAIL ss_pre_clr: got %b, expected 0", ovr_hist[1]); end
    if (hold_hist[40] !== 1'b1 || ovr_hist[40] !== 1'b0) begin
      tests_failed++; $display("FAIL ss_accept: got hold=%b ovr=%b, expected hold=1 ovr=0", hold_hist[40], ovr_hist[40]);
    end
    if (hold_hist[80] !== 1'b0 || tx_hist[80] !== 1'b0) begin
      tests_failed++; $display("FAIL ss_third: got hold=%b tx=%b, expected 0 0", hold_hist[80], tx_hist[80]);
    end
    if (blen != 30 * CPB) begin tests_failed++; $display("FAIL ss_busy_len: got %0d, expected %0d", blen, 30 * CPB); end
    if (tx_overrun !== 1'b0) begin tests_failed++; $display("FAIL ss_ovr: got %b, expected 0", tx_overrun); end
  endtask

  // Loads `b`, waits `at_t` cycles into the frame, then asserts reset between clock edges.
  task automatic async_reset_in_frame(input logic [7:0] b, input int at_t);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    repeat (1 + at_t) @(negedge clk);
    tests_run++;
    if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_busy: got %b, expected 1", tx_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run += 2;
    if (tx_serial !== 1'b1) begin tests_failed++; $display("FAIL rst_async_tx: got %b, expected 1", tx_serial); end
    if (tx_busy !== 1'b0 || hold_full !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async_state: got busy=%b hold=%b, expected 0 0", tx_busy, hold_full);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int blen;
    async_reset_in_frame(8'hFF, 10);
    async_reset_in_frame(8'h0F, 1);
    run_seq(8'h00, 0, -1, blen);
    tests_run += 2;
    if (blen != 10 * CPB) begin tests_failed++; $display("FAIL rst_recover_len: got %0d, expected %0d", blen, 10 * CPB); end
    if (tx_hist[9 * CPB - 1] !== 1'b0 || tx_hist[9 * CPB] !== 1'b1) begin
      tests_failed++; $display("FAIL rst_recover_stop: got %b%b, expected 01", tx_hist[9 * CPB - 1], tx_hist[9 * CPB]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_ovr_clr();
    test_stop_start_load();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL sb_drain: got %0d bytes still pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
